// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite blitter slice.
package sprite_pkg;

  localparam int SPRITE_W        = 56;
  localparam int SPRITE_H        = 56;
  localparam int SHEET_W         = 224;
  localparam int FB_W            = 640;
  localparam int FB_H            = 480;
  localparam int ROM_AW          = 19;
  localparam int PAL_W           = 6;
  localparam int CNT_W           = 6;
  localparam int TRANSPARENT_IDX = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } blit_state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster-order pixel walker for one sprite tile: produces the sprite-sheet
// read address, the frame-buffer destination address, a clip flag for
// pixels falling off the right/bottom edge, and a flag on the final pixel.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        tile_col,
  input  logic [1:0]        tile_row,
  input  logic [9:0]        dest_x,
  input  logic [9:0]        dest_y,
  output logic [ROM_AW-1:0] src_addr,
  output logic [ROM_AW-1:0] dst_addr,
  output logic              clip,
  output logic              last
);

  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  y_q, y_d;
  logic [10:0]       sum_x, sum_y;
  logic [ROM_AW-1:0] src_line;

  // Step x fastest, wrap into the next row; a new blit restarts at (0,0)
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_q == CNT_W'(SPRITE_W - 1)) begin
        x_d = '0;
        y_d = (y_q == CNT_W'(SPRITE_H - 1)) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Source/destination arithmetic; 11-bit sums so off-screen pixels clip
  // instead of wrapping into the next row or frame
  always_comb begin
    src_line = ROM_AW'(tile_row) * ROM_AW'(SPRITE_H) + ROM_AW'(y_q);
    src_addr = src_line * ROM_AW'(SHEET_W)
             + ROM_AW'(tile_col) * ROM_AW'(SPRITE_W) + ROM_AW'(x_q);
    sum_x    = {1'b0, dest_x} + 11'(x_q);
    sum_y    = {1'b0, dest_y} + 11'(y_q);
    clip     = (sum_x >= 11'(FB_W)) || (sum_y >= 11'(FB_H));
    dst_addr = ROM_AW'(sum_y) * ROM_AW'(FB_W) + ROM_AW'(sum_x);
    last     = (x_q == CNT_W'(SPRITE_W - 1)) && (y_q == CNT_W'(SPRITE_H - 1));
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one tile from a sync-read palette-index ROM into
// the frame buffer. Two-stage pipeline: address issue, then output stage
// whose pixel data comes straight from the ROM (or from a hold register
// while the frame buffer back-pressures).
// Optional feature macro: SPRITE_BLIT_TRANSPARENCY_EN (skip TRANSPARENT_IDX).
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [3:0]        tile_idx,
  input  logic [9:0]        dest_x,
  input  logic [9:0]        dest_y,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [PAL_W-1:0]  rom_data,
  output logic              fb_we,
  output logic [ROM_AW-1:0] fb_addr,
  output logic [PAL_W-1:0]  fb_data,
  input  logic              fb_ready
);

  blit_state_t       state_q, state_d;
  logic [3:0]        tile_q, tile_d;
  logic [9:0]        dest_x_q, dest_x_d;
  logic [9:0]        dest_y_q, dest_y_d;
  logic              out_write_q, out_write_d;
  logic [ROM_AW-1:0] fb_addr_q, fb_addr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [PAL_W-1:0]  hold_data_q, hold_data_d;

  logic              gen_clear, gen_advance, stage_adv, transparent_hit;
  logic [PAL_W-1:0]  pix_data;
  logic [ROM_AW-1:0] src_addr, dst_addr;
  logic              clip, last;

  sprite_addr_gen u_addr_gen (
    .clk      (Clk),
    .reset    (Reset),
    .clear    (gen_clear),
    .advance  (gen_advance),
    .tile_col (tile_q[1:0]),
    .tile_row (tile_q[3:2]),
    .dest_x   (dest_x_q),
    .dest_y   (dest_y_q),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .clip     (clip),
    .last     (last)
  );

  // Output-stage pixel: once stalled, the ROM already shows the next pixel,
  // so the stalled pixel is replayed from the hold register
  always_comb begin
    pix_data = hold_valid_q ? hold_data_q : rom_data;
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    transparent_hit = (pix_data == PAL_W'(TRANSPARENT_IDX));
`else
    transparent_hit = 1'b0;
`endif
    fb_we     = out_write_q && !transparent_hit;
    stage_adv = !fb_we || fb_ready;
    fb_data   = fb_we ? pix_data : '0;
    fb_addr   = fb_addr_q;
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    rom_addr  = (state_q == RUN) ? src_addr : '0;
  end

  // Next-state and pipeline control
  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    dest_x_d     = dest_x_q;
    dest_y_d     = dest_y_q;
    out_write_d  = out_write_q;
    fb_addr_d    = fb_addr_q;
    hold_valid_d = fb_we && !fb_ready;
    hold_data_d  = pix_data;
    gen_clear    = 1'b0;
    gen_advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          tile_d    = tile_idx;
          dest_x_d  = dest_x;
          dest_y_d  = dest_y;
          gen_clear = 1'b1;
        end
      end
      RUN: begin
        if (stage_adv) begin
          gen_advance = 1'b1;
          out_write_d = !clip;
          fb_addr_d   = dst_addr;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stage_adv) begin
          out_write_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers; reset aborts any blit in progress
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      tile_q       <= '0;
      dest_x_q     <= '0;
      dest_y_q     <= '0;
      out_write_q  <= 1'b0;
      fb_addr_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      dest_x_q     <= dest_x_d;
      dest_y_q     <= dest_y_d;
      out_write_q  <= out_write_d;
      fb_addr_q    <= fb_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule
